// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared FSM state codes for the serial pattern detector
package seq_detect_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with synchronous clear
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // rstn is active-high here; clear beats increment, and the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rstn || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_n.sv
// rtl/seq_detect_n.sv - configurable serial bit-pattern detector with overlap control
module seq_detect_n
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [PAT_W-1:0]   cfg_pattern,
    input  logic               cfg_overlap,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    state_t            state_q;
    logic [PAT_W-1:0]  pattern_q;
    logic              overlap_q;
    logic [PAT_W-1:0]  shreg;
    logic [PAT_W-1:0]  shift_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic              active;
    logic              match;

    assign shift_next = {shreg[PAT_W-2:0], x};
    assign fill_next  = (fill == FULL) ? FULL : fill + FILL_W'(1);
    assign active     = (state_q == FILL) || (state_q == DETECT);
    // A bit arriving alongside cfg_load is dropped, so it can never complete a match
    assign match      = active && x_valid && !cfg_load &&
                        (fill_next == FULL) && (shift_next == pattern_q);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            overlap_q <= 1'b0;
            shreg     <= '0;
            fill      <= '0;
            out       <= 1'b0;
        end else if (cfg_load) begin
            state_q   <= FILL;
            pattern_q <= cfg_pattern;
            overlap_q <= cfg_overlap;
            shreg     <= '0;
            fill      <= '0;
            out       <= 1'b0;
        end else begin
            out <= 1'b0;
            case (state_q)
                IDLE: ;
                FILL, DETECT: begin
                    if (x_valid) begin
                        out <= match;
                        if (match && !overlap_q) begin
                            shreg   <= '0;
                            fill    <= '0;
                            state_q <= FILL;
                        end else begin
                            shreg   <= shift_next;
                            fill    <= fill_next;
                            state_q <= (fill_next == FULL) ? DETECT : FILL;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk (clk),
        .rstn(rstn),
        .clr (cfg_load),
        .inc (match),
        .cnt (match_cnt)
    );

    assign state = state_q;

endmodule

// File: tb/tb_seq_detect_n.sv
// tb/tb_seq_detect_n.sv - directed vector table plus randomized run against a history-based model
module tb_seq_detect_n;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rstn;
    logic             x;
    logic             x_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic [1:0]       state;

    seq_detect_n #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .x          (x),
        .x_valid    (x_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
        .out        (out),
        .match_cnt  (match_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       load;
        bit [3:0] pat;
        bit       ovl;
        bit       xv;
        bit       xb;
        bit       e_out;
        int       e_cnt;
        int       e_st;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: remembers the accepted bits since the last restart and looks at the newest PAT_W
    bit       m_configured;
    bit [3:0] m_pat;
    bit       m_ovl;
    bit       hist[$];
    int       m_cnt;
    bit       m_out;

    function automatic void model_step(bit r, bit l, bit [3:0] p, bit o, bit v, bit b);
        bit hit;
        if (r) begin
            m_configured = 0; m_pat = 0; m_ovl = 0; hist.delete(); m_cnt = 0; m_out = 0;
        end else if (l) begin
            m_configured = 1; m_pat = p; m_ovl = o; hist.delete(); m_cnt = 0; m_out = 0;
        end else begin
            m_out = 0;
            if (m_configured && v) begin
                hist.push_back(b);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                hit = (hist.size() == PAT_W);
                for (int i = 0; i < PAT_W; i++)
                    if (hist.size() == PAT_W && hist[i] != m_pat[PAT_W-1-i]) hit = 0;
                if (hit) begin
                    m_out = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!m_ovl) hist.delete();
                end
            end
        end
    endfunction

    function automatic int model_state();
        if (!m_configured) return 0;
        return (hist.size() >= PAT_W) ? 2 : 1;
    endfunction

    function automatic void add(bit r, bit l, bit [3:0] p, bit o, bit v, bit b, bit eo, int ec, int es);
        vec_t t;
        t.rst = r; t.load = l; t.pat = p; t.ovl = o; t.xv = v; t.xb = b;
        t.e_out = eo; t.e_cnt = ec; t.e_st = es;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit l, input bit [3:0] p, input bit o, input bit v, input bit b);
        rstn = r; cfg_load = l; cfg_pattern = p; cfg_overlap = o; x_valid = v; x = b;
        @(posedge clk);
        model_step(r, l, p, o, v, b);
        #1;
    endtask

    initial begin
        clk = 0;
        rstn = 1; cfg_load = 0; cfg_pattern = 0; cfg_overlap = 0; x_valid = 0; x = 0;

        // reset state
        add(1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        // 1011 overlapping over 1,0,1,1,0,1,1
        add(0, 1, 4'hB, 1, 0, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 1, 1, 2);
        add(0, 0, 4'h0, 0, 1, 0, 0, 1, 2);
        add(0, 0, 4'h0, 0, 1, 1, 0, 1, 2);
        add(0, 0, 4'h0, 0, 1, 1, 1, 2, 2);
        add(0, 0, 4'h0, 0, 0, 1, 0, 2, 2);
        // same stream non-overlapping
        add(0, 1, 4'hB, 0, 0, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 1, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 1, 1);
        // valid gaps between bits 2 and 3
        add(0, 1, 4'hB, 1, 0, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 0, 0, i[0], 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 1, 1, 2);
        add(0, 0, 4'h0, 0, 0, 1, 0, 1, 2);
        // 1111 overlapping, counter saturates at 3
        add(0, 1, 4'hF, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 1, 1, 2);
        add(0, 0, 4'h0, 0, 1, 1, 1, 2, 2);
        for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 0, 1, 1, 1, 3, 2);
        // config inputs moving without cfg_load are ignored
        add(0, 0, 4'h0, 0, 1, 1, 1, 3, 2);
        // reset mid-stream beats cfg_load and x_valid, then IDLE ignores data
        add(0, 1, 4'hB, 1, 0, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(1, 1, 4'hB, 1, 1, 1, 0, 0, 0);
        add(0, 0, 4'hB, 1, 1, 1, 0, 0, 0);
        add(0, 0, 4'hB, 1, 1, 0, 0, 0, 0);
        add(0, 0, 4'hB, 1, 1, 1, 0, 0, 0);
        add(0, 0, 4'hB, 1, 1, 1, 0, 0, 0);
        // bit on the cfg_load edge is dropped; fill completes without a match
        add(0, 1, 4'hB, 1, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 0, 0, 2);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].load, tbl[i].pat, tbl[i].ovl, tbl[i].xv, tbl[i].xb);
            chk($sformatf("vec%0d out", i), int'(out), int'(tbl[i].e_out));
            chk($sformatf("vec%0d match_cnt", i), int'(match_cnt), tbl[i].e_cnt);
            chk($sformatf("vec%0d state", i), int'(state), tbl[i].e_st);
        end

        for (int n = 0; n < 3000; n++) begin
            bit       r, l, o, v, b;
            bit [3:0] p;
            r = ($urandom_range(99) == 0);
            l = ($urandom_range(19) == 0);
            p = 4'($urandom_range(15));
            o = 1'($urandom_range(1));
            v = ($urandom_range(3) != 0);
            b = 1'($urandom_range(1));
            apply(r, l, p, o, v, b);
            chk("rand out", int'(out), int'(m_out));
            chk("rand match_cnt", int'(match_cnt), m_cnt);
            chk("rand state", int'(state), model_state());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
